fgmt_refill_arbiter: RTL and testbench
======================================

# fgmt_refill_arbiter

Collects miss, branch and prefetch requests from the per-thread L1 instruction caches and serialises them into a single L2 request channel. It tracks one outstanding line fill per thread and broadcasts each L2 fill back to every L1 cache, tagged with thread ID and line address. It sits directly downstream of the L1 caches, between them and L2.

## Interface
Parameters:
- THREADS, 4, number of hardware threads / L1 instances; must equal 2**TID_bits
- QDEPTH, 2, depth of the L2 response skid register (1 or 2)

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- req_refill  in  THREADS  per-thread demand-miss request, level
- req_spec  in  THREADS  per-thread sequential prefetch request, level
- br_req  in  THREADS  per-thread branch-target request, level
- req_addr  in  THREADS x word  per-thread request address (PC or branch target)
- mem_req_valid  out  1  request to L2 valid
- mem_req_ready  in  1  L2 accepts request
- mem_req_addr  out  word  line-aligned request address, [3:0]=0
- mem_req_tid  out  TID_bits  requesting thread
- mem_rsp_valid  in  1  L2 fill valid
- mem_rsp_tid  in  TID_bits  fill thread
- mem_rsp_line  in  line  fill data
- l2_valid_rsp  out  1  fill broadcast to L1s, one-cycle pulse
- l2_tid  out  TID_bits  broadcast thread
- l2addr  out  word  broadcast line address
- l2_line  out  line  broadcast data

## Operation
- Per-thread state: pending bit, stale bit, pend_addr (word, [3:0]=0).
- Eligibility: thread t is eligible when not pending. Class priority: br_req > req_refill > req_spec. Round-robin within the winning class; the pointer advances to winner+1 on each grant.
- Request address: br_req/req_refill give {req_addr[31:4],4'b0}. req_spec gives {req_addr[31:4],4'b0}+16, wrapping modulo 2**32.
- FSM: IDLE -> ISSUE on a grant, latching addr and tid. ISSUE -> IDLE on mem_req_valid && mem_req_ready. No arbitration happens in ISSUE.
- A grant sets pending[t] and pend_addr[t] and clears stale[t].
- br_req from a pending thread whose line differs from pend_addr sets stale[t]. No new request is issued. The L1 holds br_req stable, so it re-arbitrates once pending clears.
- Fill with mem_rsp_tid=t:
  - Clear pending[t].
  - If stale[t]=0, broadcast {pend_addr[t], line, t}.
  - If stale[t]=1, drop the fill, clear stale, and broadcast nothing.
- A fill for a non-pending thread is dropped. The `FGMT_ASSERT` protocol check flags it in simulation.
- A fill and a grant to the same thread in the same cycle: the fill clears pending first, so the thread is eligible that same cycle.

## Timing
- Reset values: mem_req_valid=0, mem_req_addr=0, mem_req_tid=0, l2_valid_rsp=0, l2_tid=0, l2addr=0, l2_line=0. All pending and stale bits cleared, RR pointer=0, FSM=IDLE.
- Grant in cycle N (combinational on inputs): mem_req_valid=1 from N+1. Address and tid are held stable until the handshake.
- Back-to-back throughput: one request every 2 cycles (handshake cycle, then IDLE grant).
- Fill: mem_rsp_valid in cycle M gives l2_valid_rsp=1 in M+1 for exactly one cycle. L2 never back-pressures fills. QDEPTH only registers them.
- Reset asserted mid-ISSUE: mem_req_valid drops the next cycle. Fills arriving after reset are dropped as non-pending.

## Configuration
- FGMT_PREFETCH_EN defined: req_spec participates as the lowest class.
- FGMT_PREFETCH_EN undefined: req_spec is ignored and never granted. The +16 adder and spec class logic are compiled out.

## Structure
- fgmt package: word, line, TID_bits, block_size, WIDTH, set/clear. Add arb_state_t (IDLE, ISSUE), req_class_t (BR, REFILL, SPEC) and LINE_BYTES=16.
- Sub-module rr_arbiter: parameterised THREADS-wide round-robin picker (req vector, pointer in; one-hot grant out). Instantiated once per class, with a class-priority mux after it.

## Test plan
- Thread 2 req_refill, req_addr=0x0000_1234 -> cycle+1: mem_req_valid, addr=0x0000_1230, tid=2. Fill returned -> next cycle l2_valid_rsp pulse, l2addr=0x0000_1230, l2_tid=2.
- Threads 0 and 1 req_refill and thread 3 br_req in the same cycle -> thread 3 issued first. Then threads 0 and 1 in round-robin order.
- With FGMT_PREFETCH_EN, thread 1 req_spec, addr=0xFFFF_FFF8 -> mem_req_addr=0x0000_0000. Without the macro -> no request.
- Thread 0 pending on 0x100, br_req to 0x200 -> fill for 0x100 not broadcast. Next request is 0x200, tid 0.
- mem_req_ready held low 5 cycles -> mem_req_valid, addr and tid stable for all 5 cycles. No second grant.
- Reset asserted while in ISSUE -> mem_req_valid=0 the next cycle and all outputs at reset values. A following fill produces no l2_valid_rsp.

Source files
------------

// File: rtl/fgmt_refill_arbiter_pkg.sv
// Shared types and constants for the L1I refill arbiter.
// Provides the word/line data types, thread-id width, line geometry, FSM and
// request-class enumerations, and a line-alignment helper.
package fgmt_refill_arbiter_pkg;

   localparam int WIDTH      = 32;
   localparam int TID_bits   = 2;
   localparam int block_size = 16;
   localparam int LINE_BYTES = 16;

   localparam logic SET   = 1'b1;
   localparam logic CLEAR = 1'b0;

   typedef logic [WIDTH-1:0]        word;
   typedef logic [8*block_size-1:0] line;

   typedef enum logic { IDLE, ISSUE } arb_state_t;
   typedef enum logic [1:0] { BR, REFILL, SPEC } req_class_t;

   function automatic word line_align(input word a);
      return a & ~word'(LINE_BYTES - 1);
   endfunction

endpackage

// File: rtl/fgmt_refill_arbiter_rr_arbiter.sv
// rr_arbiter: N-wide round-robin picker.
// Ports:
//   req   - request vector, one bit per thread
//   ptr   - index of the highest-priority thread this cycle
//   grant - one-hot grant (all zero when no request)
// N must be a power of two so the index wraps naturally in PTR_W bits.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   logic [PTR_W-1:0] idx;

   // Walk from the farthest slot back towards ptr so the request closest to
   // ptr is the last one written and therefore wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = ptr + PTR_W'(i);
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fgmt_refill_arbiter.sv
// fgmt_refill_arbiter: serialises per-thread L1I branch / demand-miss /
// sequential-prefetch requests onto one L2 request channel, tracks one
// outstanding fill per thread and broadcasts fills back to every L1.
// Ports:
//   clock, reset                          - clock, synchronous active-high reset
//   req_refill, req_spec, br_req          - per-thread level requests
//   req_addr                              - per-thread address, thread t at [t*32 +: 32]
//   mem_req_valid/ready/addr/tid          - L2 request channel
//   mem_rsp_valid/tid/line                - L2 fill input (never back-pressured)
//   l2_valid_rsp, l2_tid, l2addr, l2_line - registered fill broadcast
// Build option: FGMT_PREFETCH_EN enables req_spec as the lowest-priority class.
// Build option: FGMT_ASSERT enables the fill-for-non-pending-thread check.
module fgmt_refill_arbiter
   import fgmt_refill_arbiter_pkg::*;
#(
   parameter int THREADS = 4,
   parameter int QDEPTH  = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [THREADS-1:0]        req_refill,
   input  logic [THREADS-1:0]        req_spec,
   input  logic [THREADS-1:0]        br_req,
   input  logic [THREADS*WIDTH-1:0]  req_addr,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [WIDTH-1:0]          mem_req_addr,
   output logic [TID_bits-1:0]       mem_req_tid,
   input  logic                      mem_rsp_valid,
   input  logic [TID_bits-1:0]       mem_rsp_tid,
   input  logic [8*block_size-1:0]   mem_rsp_line,
   output logic                      l2_valid_rsp,
   output logic [TID_bits-1:0]       l2_tid,
   output logic [WIDTH-1:0]          l2addr,
   output logic [8*block_size-1:0]   l2_line
);

   if (THREADS != (1 << TID_bits)) begin : g_bad_threads
      $error("THREADS must equal 2**TID_bits");
   end
   if (QDEPTH < 1 || QDEPTH > 2) begin : g_bad_qdepth
      $error("QDEPTH must be 1 or 2");
   end

   arb_state_t          state, state_nx;
   req_class_t          win_class;
   logic [THREADS-1:0]  pending, stale, stale_set;
   logic [WIDTH-1:0]    pend_addr [THREADS];
   logic [WIDTH-1:0]    addr_arr  [THREADS];
   logic [TID_bits-1:0] rr_ptr, grant_tid;
   logic [THREADS-1:0]  fill_hot, pend_eff, br_v, rf_v, br_g, rf_g, sp_g, grant;
   logic [WIDTH-1:0]    grant_addr;
   logic                fill_hit, any_grant, grant_en, take, rsp_vld_p0;

   for (genvar g = 0; g < THREADS; g++) begin : g_addr
      assign addr_arr[g] = req_addr[g*WIDTH +: WIDTH];
   end

   // A fill retires its thread before arbitration looks at it, so the same
   // thread can be re-granted in the fill cycle.
   assign fill_hit   = mem_rsp_valid && pending[mem_rsp_tid];
   assign fill_hot   = fill_hit ? (THREADS'(1) << mem_rsp_tid) : '0;
   assign pend_eff   = pending & ~fill_hot;
   assign rsp_vld_p0 = fill_hit && !stale[mem_rsp_tid];

   assign br_v = br_req     & ~pend_eff;
   assign rf_v = req_refill & ~pend_eff;

   rr_arbiter #(.N(THREADS), .PTR_W(TID_bits)) u_rr_br (.req(br_v), .ptr(rr_ptr), .grant(br_g));
   rr_arbiter #(.N(THREADS), .PTR_W(TID_bits)) u_rr_rf (.req(rf_v), .ptr(rr_ptr), .grant(rf_g));

`ifdef FGMT_PREFETCH_EN
   logic [THREADS-1:0] sp_v;
   assign sp_v = req_spec & ~pend_eff;
   rr_arbiter #(.N(THREADS), .PTR_W(TID_bits)) u_rr_sp (.req(sp_v), .ptr(rr_ptr), .grant(sp_g));
`else
   logic unused_req_spec;
   assign unused_req_spec = ^req_spec;
   assign sp_g            = '0;
`endif

   always_comb begin
      win_class = REFILL;
      if (|br_v)
         win_class = BR;
      else if (|rf_v)
         win_class = REFILL;
`ifdef FGMT_PREFETCH_EN
      else if (|sp_v)
         win_class = SPEC;
`endif
      case (win_class)
         BR:      grant = br_g;
         REFILL:  grant = rf_g;
         default: grant = sp_g;
      endcase
   end

   assign any_grant = |grant;

   always_comb begin
      grant_tid = '0;
      for (int t = 0; t < THREADS; t++)
         if (grant[t]) grant_tid = TID_bits'(t);
   end

   always_comb begin
      grant_addr = line_align(addr_arr[grant_tid]);
`ifdef FGMT_PREFETCH_EN
      // Sequential prefetch targets the next line; wraps at the top of memory.
      if (win_class == SPEC)
         grant_addr = grant_addr + word'(LINE_BYTES);
`endif
   end

   // A branch to a different line while a fill is outstanding makes that fill useless.
   always_comb begin
      stale_set = '0;
      for (int t = 0; t < THREADS; t++)
         stale_set[t] = pend_eff[t] && br_req[t] && (line_align(addr_arr[t]) != pend_addr[t]);
   end

   always_comb begin
      state_nx      = state;
      mem_req_valid = CLEAR;
      grant_en      = CLEAR;
      case (state)
         IDLE: begin
            grant_en = SET;
            if (any_grant) state_nx = ISSUE;
         end
         ISSUE: begin
            mem_req_valid = SET;
            if (mem_req_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign take = grant_en && any_grant;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Request stage: per-thread bookkeeping and the held L2 request.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending      <= '0;
         stale        <= '0;
         rr_ptr       <= '0;
         mem_req_addr <= '0;
         mem_req_tid  <= '0;
      end else begin
         pending <= pend_eff | (take ? grant : '0);
         stale   <= (stale & ~fill_hot & ~(take ? grant : '0)) | stale_set;
         if (take) begin
            mem_req_addr <= grant_addr;
            mem_req_tid  <= grant_tid;
            rr_ptr       <= grant_tid + TID_bits'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (take) pend_addr[grant_tid] <= grant_addr;
   end

   // Response stage: one-cycle registered broadcast of non-stale fills.
   always_ff @(posedge clock) begin
      if (reset) begin
         l2_valid_rsp <= 1'b0;
         l2_tid       <= '0;
         l2addr       <= '0;
         l2_line      <= '0;
      end else begin
         l2_valid_rsp <= rsp_vld_p0;
         if (rsp_vld_p0) begin
            l2_tid  <= mem_rsp_tid;
            l2addr  <= pend_addr[mem_rsp_tid];
            l2_line <= mem_rsp_line;
         end
      end
   end

`ifdef FGMT_ASSERT
   a_fill_pending: assert property (@(posedge clock) disable iff (reset)
      mem_rsp_valid |-> pending[mem_rsp_tid])
      else $warning("fill for non-pending thread %0d dropped", mem_rsp_tid);
`endif

endmodule

// File: tb/tb_fgmt_refill_arbiter.sv
// Self-checking bench for fgmt_refill_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbitration rules.
module tb_fgmt_refill_arbiter;
   import fgmt_refill_arbiter_pkg::*;

   localparam int T = 4;
`ifdef FGMT_PREFETCH_EN
   localparam bit SPEC_EN = 1'b1;
`else
   localparam bit SPEC_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic [T-1:0]  req_refill, req_spec, br_req;
   logic [T*32-1:0] req_addr;
   logic          mem_req_valid, mem_req_ready;
   logic [31:0]   mem_req_addr;
   logic [1:0]    mem_req_tid;
   logic          mem_rsp_valid;
   logic [1:0]    mem_rsp_tid;
   logic [127:0]  mem_rsp_line;
   logic          l2_valid_rsp;
   logic [1:0]    l2_tid;
   logic [31:0]   l2addr;
   logic [127:0]  l2_line;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   fgmt_refill_arbiter #(.THREADS(T), .QDEPTH(2)) dut (
      .clock(clock), .reset(reset),
      .req_refill(req_refill), .req_spec(req_spec), .br_req(br_req), .req_addr(req_addr),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_tid(mem_req_tid),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tid(mem_rsp_tid), .mem_rsp_line(mem_rsp_line),
      .l2_valid_rsp(l2_valid_rsp), .l2_tid(l2_tid), .l2addr(l2addr), .l2_line(l2_line)
   );

   // Behavioural model: requests outstanding per thread, one channel slot.
   bit           m_pend [T];
   bit           m_stale[T];
   logic [31:0]  m_paddr[T];
   int           m_ptr;
   bit           m_busy;
   logic [31:0]  m_qaddr;
   logic [1:0]   m_qtid;
   bit           e_l2v;
   logic [1:0]   e_l2tid;
   logic [31:0]  e_l2addr;
   logic [127:0] e_l2line;

   function automatic logic [31:0] addr_of(int t);
      return req_addr[t*32 +: 32];
   endfunction

   function automatic bit wants(int c, int t);
      if (c == 0) return br_req[t];
      if (c == 1) return req_refill[t];
      return SPEC_EN && req_spec[t];
   endfunction

   task automatic model_step();
      int win, cls;
      logic [31:0] a;
      if (reset) begin
         for (int t = 0; t < T; t++) begin m_pend[t] = 0; m_stale[t] = 0; end
         m_ptr = 0; m_busy = 0; m_qaddr = 0; m_qtid = 0;
         e_l2v = 0; e_l2tid = 0; e_l2addr = 0; e_l2line = 0;
         return;
      end
      e_l2v = 0;
      if (mem_rsp_valid && m_pend[mem_rsp_tid]) begin
         m_pend[mem_rsp_tid] = 0;
         if (m_stale[mem_rsp_tid]) m_stale[mem_rsp_tid] = 0;
         else begin
            e_l2v = 1; e_l2tid = mem_rsp_tid;
            e_l2addr = m_paddr[mem_rsp_tid]; e_l2line = mem_rsp_line;
         end
      end
      for (int t = 0; t < T; t++)
         if (m_pend[t] && br_req[t] && ((addr_of(t) & 32'hFFFF_FFF0) != m_paddr[t]))
            m_stale[t] = 1;
      if (m_busy) begin
         if (mem_req_ready) m_busy = 0;
      end else begin
         win = -1; cls = -1;
         for (int c = 0; c < 3; c++)
            for (int k = 0; k < T; k++) begin
               int t;
               t = (m_ptr + k) % T;
               if (win < 0 && !m_pend[t] && wants(c, t)) begin win = t; cls = c; end
            end
         if (win >= 0) begin
            a = addr_of(win) & 32'hFFFF_FFF0;
            if (cls == 2) a = a + 32'd16;
            m_busy = 1; m_qaddr = a; m_qtid = 2'(win);
            m_pend[win] = 1; m_paddr[win] = a; m_stale[win] = 0;
            m_ptr = (win + 1) % T;
         end
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_addr(int t, logic [31:0] a);
      req_addr[t*32 +: 32] = a;
   endtask

   task automatic clear_inputs();
      req_refill = '0; req_spec = '0; br_req = '0; req_addr = '0;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_tid = 0; mem_rsp_line = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1; cyc(); cyc();
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      req_refill = 4'hF; br_req = 4'h5; req_addr = {$urandom, $urandom, $urandom, $urandom};
      mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_tid = 2'd1; mem_rsp_line = {4{$urandom}};
      cyc(); cyc();
      n_tests++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", mem_req_valid); end
      n_tests++; if (mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_req_addr); end
      n_tests++; if (mem_req_tid !== 2'd0) begin n_fail++; $display("FAIL reset_tid: got %0d want 0", mem_req_tid); end
      n_tests++; if (l2_valid_rsp !== 1'b0) begin n_fail++; $display("FAIL reset_l2v: got %0b want 0", l2_valid_rsp); end
      n_tests++; if (l2_tid !== 2'd0) begin n_fail++; $display("FAIL reset_l2tid: got %0d want 0", l2_tid); end
      n_tests++; if (l2addr !== 32'h0) begin n_fail++; $display("FAIL reset_l2addr: got %h want 0", l2addr); end
      n_tests++; if (l2_line !== 128'h0) begin n_fail++; $display("FAIL reset_l2line: got %h want 0", l2_line); end
      clear_inputs(); reset = 0;
   endtask

   task automatic test_single_refill();
      logic [127:0] ln;
      do_reset();
      req_refill[2] = 1; set_addr(2, 32'h0000_1234);
      cyc();
      req_refill = '0;
      n_tests++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", mem_req_valid); end
      n_tests++; if (mem_req_addr !== 32'h0000_1230) begin n_fail++; $display("FAIL single_addr: got %h want 00001230", mem_req_addr); end
      n_tests++; if (mem_req_tid !== 2'd2) begin n_fail++; $display("FAIL single_tid: got %0d want 2", mem_req_tid); end
      mem_req_ready = 1; cyc(); mem_req_ready = 0;
      n_tests++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL single_handshake: got %0b want 0", mem_req_valid); end
      ln = {$urandom, $urandom, $urandom, $urandom};
      mem_rsp_valid = 1; mem_rsp_tid = 2'd2; mem_rsp_line = ln;
      cyc();
      mem_rsp_valid = 0;
      n_tests++; if (l2_valid_rsp !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %0b want 1", l2_valid_rsp); end
      n_tests++; if (l2addr !== 32'h0000_1230) begin n_fail++; $display("FAIL fill_addr: got %h want 00001230", l2addr); end
      n_tests++; if (l2_tid !== 2'd2) begin n_fail++; $display("FAIL fill_tid: got %0d want 2", l2_tid); end
      n_tests++; if (l2_line !== ln) begin n_fail++; $display("FAIL fill_line: got %h want %h", l2_line, ln); end
      cyc();
      n_tests++; if (l2_valid_rsp !== 1'b0) begin n_fail++; $display("FAIL fill_pulse: got %0b want 0", l2_valid_rsp); end
   endtask

   task automatic test_priority();
      do_reset();
      req_refill = 4'b0011; br_req = 4'b1000;
      set_addr(0, 32'h100); set_addr(1, 32'h200); set_addr(3, 32'h3008);
      cyc();
      n_tests++; if (mem_req_valid !== 1'b1 || mem_req_tid !== 2'd3 || mem_req_addr !== 32'h3000) begin
         n_fail++; $display("FAIL prio_br: got v=%0b tid=%0d addr=%h want v=1 tid=3 addr=00003000", mem_req_valid, mem_req_tid, mem_req_addr); end
      mem_req_ready = 1; cyc(); mem_req_ready = 0;
      n_tests++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL prio_gap: got %0b want 0", mem_req_valid); end
      cyc();
      n_tests++; if (mem_req_valid !== 1'b1 || mem_req_tid !== 2'd0 || mem_req_addr !== 32'h100) begin
         n_fail++; $display("FAIL prio_rr0: got v=%0b tid=%0d addr=%h want v=1 tid=0 addr=00000100", mem_req_valid, mem_req_tid, mem_req_addr); end
      mem_req_ready = 1; cyc(); mem_req_ready = 0;
      cyc();
      n_tests++; if (mem_req_valid !== 1'b1 || mem_req_tid !== 2'd1 || mem_req_addr !== 32'h200) begin
         n_fail++; $display("FAIL prio_rr1: got v=%0b tid=%0d addr=%h want v=1 tid=1 addr=00000200", mem_req_valid, mem_req_tid, mem_req_addr); end
      clear_inputs();
   endtask

   task automatic test_prefetch();
      do_reset();
      req_spec[1] = 1; set_addr(1, 32'hFFFF_FFF8);
`ifdef FGMT_PREFETCH_EN
      cyc();
      n_tests++; if (mem_req_valid !== 1'b1 || mem_req_tid !== 2'd1 || mem_req_addr !== 32'h0) begin
         n_fail++; $display("FAIL spec_wrap: got v=%0b tid=%0d addr=%h want v=1 tid=1 addr=00000000", mem_req_valid, mem_req_tid, mem_req_addr); end
`else
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_tests++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL spec_ignored: got %0b want 0", mem_req_valid); end
      end
`endif
      clear_inputs();
   endtask

   task automatic test_stale();
      do_reset();
      req_refill[0] = 1; set_addr(0, 32'h100);
      cyc();
      req_refill = '0;
      n_tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
         n_fail++; $display("FAIL stale_first: got v=%0b addr=%h want v=1 addr=00000100", mem_req_valid, mem_req_addr); end
      mem_req_ready = 1; cyc(); mem_req_ready = 0;
      br_req[0] = 1; set_addr(0, 32'h200);
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_tests++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stale_noissue: got %0b want 0", mem_req_valid); end
      end
      mem_rsp_valid = 1; mem_rsp_tid = 2'd0; mem_rsp_line = {4{$urandom}};
      cyc();
      mem_rsp_valid = 0;
      n_tests++; if (l2_valid_rsp !== 1'b0) begin n_fail++; $display("FAIL stale_drop: got %0b want 0", l2_valid_rsp); end
      n_tests++; if (mem_req_valid !== 1'b1 || mem_req_tid !== 2'd0 || mem_req_addr !== 32'h200) begin
         n_fail++; $display("FAIL stale_reissue: got v=%0b tid=%0d addr=%h want v=1 tid=0 addr=00000200", mem_req_valid, mem_req_tid, mem_req_addr); end
      clear_inputs();
   endtask

   task automatic test_backpressure();
      do_reset();
      req_refill = 4'b0110; set_addr(1, 32'h0000_ABCD); set_addr(2, 32'h7777_0004);
      cyc();
      for (int i = 0; i < 5; i++) begin
         n_tests++; if (mem_req_valid !== 1'b1 || mem_req_tid !== 2'd1 || mem_req_addr !== 32'h0000_ABC0) begin
            n_fail++; $display("FAIL hold_%0d: got v=%0b tid=%0d addr=%h want v=1 tid=1 addr=0000abc0", i, mem_req_valid, mem_req_tid, mem_req_addr); end
         cyc();
      end
      mem_req_ready = 1; cyc(); mem_req_ready = 0;
      n_tests++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %0b want 0", mem_req_valid); end
      cyc();
      n_tests++; if (mem_req_valid !== 1'b1 || mem_req_tid !== 2'd2 || mem_req_addr !== 32'h7777_0000) begin
         n_fail++; $display("FAIL b2b_next: got v=%0b tid=%0d addr=%h want v=1 tid=2 addr=77770000", mem_req_valid, mem_req_tid, mem_req_addr); end
      clear_inputs();
   endtask

   task automatic test_reset_mid_issue();
      do_reset();
      req_refill[3] = 1; set_addr(3, 32'h5555);
      cyc();
      req_refill = '0;
      n_tests++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got %0b want 1", mem_req_valid); end
      reset = 1; cyc(); reset = 0;
      n_tests++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || mem_req_tid !== 2'd0) begin
         n_fail++; $display("FAIL midrst_req: got v=%0b tid=%0d addr=%h want all 0", mem_req_valid, mem_req_tid, mem_req_addr); end
      n_tests++; if (l2_valid_rsp !== 1'b0 || l2_tid !== 2'd0 || l2addr !== 32'h0 || l2_line !== 128'h0) begin
         n_fail++; $display("FAIL midrst_l2: got v=%0b tid=%0d addr=%h want all 0", l2_valid_rsp, l2_tid, l2addr); end
      mem_rsp_valid = 1; mem_rsp_tid = 2'd3; mem_rsp_line = {4{$urandom}};
      cyc();
      mem_rsp_valid = 0;
      n_tests++; if (l2_valid_rsp !== 1'b0) begin n_fail++; $display("FAIL midrst_fill: got %0b want 0", l2_valid_rsp); end
      clear_inputs();
   endtask

   task automatic test_random();
      int shown = 0;
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         reset = ($urandom_range(499) == 0);
         for (int t = 0; t < T; t++) begin
            br_req[t]     = ($urandom_range(3) == 0);
            req_refill[t] = ($urandom_range(2) == 0);
            req_spec[t]   = ($urandom_range(3) == 0);
            if ($urandom_range(3) == 0)
               case ($urandom_range(2))
                  0: set_addr(t, $urandom);
                  1: set_addr(t, 32'hFFFF_FFF0 | 32'($urandom_range(15)));
                  default: set_addr(t, 32'h1000 + 32'($urandom_range(3)) * 32'd16 + 32'($urandom_range(15)));
               endcase
         end
         mem_req_ready = ($urandom_range(2) != 0);
         mem_rsp_valid = 0;
         if ($urandom_range(2) == 0) begin
            int t;
            t = $urandom_range(T - 1);
            if (m_pend[t] || $urandom_range(7) == 0) begin
               mem_rsp_valid = 1; mem_rsp_tid = 2'(t);
               mem_rsp_line = {$urandom, $urandom, $urandom, $urandom};
            end
         end
         cyc();
         n_tests++; if (mem_req_valid !== m_busy) begin n_fail++; if (shown++ < 20) $display("FAIL rnd_valid@%0d: got %0b want %0b", n, mem_req_valid, m_busy); end
         n_tests++; if (mem_req_addr !== m_qaddr) begin n_fail++; if (shown++ < 20) $display("FAIL rnd_addr@%0d: got %h want %h", n, mem_req_addr, m_qaddr); end
         n_tests++; if (mem_req_tid !== m_qtid) begin n_fail++; if (shown++ < 20) $display("FAIL rnd_tid@%0d: got %0d want %0d", n, mem_req_tid, m_qtid); end
         n_tests++; if (l2_valid_rsp !== e_l2v) begin n_fail++; if (shown++ < 20) $display("FAIL rnd_l2v@%0d: got %0b want %0b", n, l2_valid_rsp, e_l2v); end
         n_tests++; if (l2_tid !== e_l2tid) begin n_fail++; if (shown++ < 20) $display("FAIL rnd_l2tid@%0d: got %0d want %0d", n, l2_tid, e_l2tid); end
         n_tests++; if (l2addr !== e_l2addr) begin n_fail++; if (shown++ < 20) $display("FAIL rnd_l2addr@%0d: got %h want %h", n, l2addr, e_l2addr); end
         n_tests++; if (l2_line !== e_l2line) begin n_fail++; if (shown++ < 20) $display("FAIL rnd_l2line@%0d: got %h want %h", n, l2_line, e_l2line); end
      end
      clear_inputs(); reset = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      reset = 1;
      test_reset();
      test_single_refill();
      test_priority();
      test_prefetch();
      test_stale();
      test_backpressure();
      test_reset_mid_issue();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
